// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage FSM issuing memory requests, pipeline stalls/flushes and traps
module mem_stage_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_ecall_instr,
    input  logic [3:0]       i_cause,
    input  logic             i_mem_ready,
    input  logic             i_mem_err,
    input  logic             i_load_use,
    input  logic             i_branch_mispred,
    output logic             o_mem_req,
    output logic             o_mem_req_we,
    output logic             o_stall_fetch,
    output logic             o_stall_dec,
    output logic             o_stall_exec,
    output logic             o_stall_mem,
    output logic             o_flush_dec,
    output logic             o_flush_exec,
    output logic             o_flush_mem,
    output logic             o_trap,
    output logic [3:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_stall_cycles
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_TRAP = 2'd2;
    logic [1:0]           state_q, state_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_nx;
    logic [3:0]           cause_q, cause_d, mem_cause;
    logic                 we_q, is_idle, is_wait, is_trap, ext_trap, mem_stall;
    assign is_idle   = state_q == S_IDLE;
    assign is_wait   = state_q == S_WAIT;
    assign is_trap   = state_q == S_TRAP;
    assign ext_trap  = i_cause != 4'd0 || i_ecall_instr;
    assign mem_cause = (is_wait ? we_q : i_mem_we) ? 4'd7 : 4'd5;
    assign tmo_nx    = tmo_q + 1'b1;
    assign mem_stall = is_idle ? i_mem_access && !i_mem_ready && !ext_trap : is_wait && !i_mem_ready;
    // next state and trap cause; higher-priority trap sources pre-empt a memory miss
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        if (is_idle) begin
            if (ext_trap) begin
                state_d = S_TRAP;
                cause_d = (i_cause != 4'd0) ? i_cause : 4'd11;
            end else if (i_mem_access && i_mem_ready && i_mem_err) begin
                state_d = S_TRAP;
                cause_d = mem_cause;
            end else if (mem_stall) begin
                state_d = S_WAIT;
            end
        end else if (is_wait) begin
            if (i_mem_ready && !i_mem_err) begin
                state_d = S_IDLE;
            end else if (i_mem_ready || tmo_nx == '1) begin
                state_d = S_TRAP;
                cause_d = mem_cause;
            end
        end else begin
            state_d = S_IDLE;
        end
    end
    // outputs are gated by reset so they read 0 immediately while it is held
    assign o_mem_req     = i_arst_n && (is_wait || (is_idle && i_mem_access));
    assign o_mem_req_we  = i_arst_n && (is_wait ? we_q : is_idle && i_mem_we);
    assign o_stall_fetch = i_arst_n && (mem_stall || (is_idle && !i_branch_mispred && i_load_use));
    assign o_stall_dec   = o_stall_fetch;
    assign o_stall_exec  = i_arst_n && mem_stall;
    assign o_stall_mem   = i_arst_n && mem_stall;
    assign o_flush_dec   = i_arst_n && (is_trap || (is_idle && !mem_stall && i_branch_mispred));
    assign o_flush_exec  = i_arst_n && (is_trap || (is_idle && !mem_stall && (i_branch_mispred || i_load_use)));
    assign o_flush_mem   = i_arst_n && is_trap;
    assign o_trap        = i_arst_n && is_trap;
    assign o_trap_cause  = o_trap ? cause_q : 4'd0;
    // state, timeout, latched store flag and saturating stall statistics
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q        <= S_IDLE;
            tmo_q          <= '0;
            cause_q        <= 4'd0;
            we_q           <= 1'b0;
            o_stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tmo_q   <= is_wait ? tmo_nx : '0;
            if (is_idle) we_q <= i_mem_we;
            if (o_stall_mem && o_stall_cycles != '1) o_stall_cycles <= o_stall_cycles + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic       i_clk = 1'b0;
    logic       i_arst_n, i_mem_access, i_mem_we, i_ecall_instr, i_mem_ready, i_mem_err, i_load_use, i_branch_mispred;
    logic [3:0] i_cause;
    logic       o_mem_req, o_mem_req_we, o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem;
    logic       o_flush_dec, o_flush_exec, o_flush_mem, o_trap;
    logic [3:0] o_trap_cause;
    logic [3:0] o_stall_cycles;
    logic [6:0] ctl;
    int         n_cmp = 0;
    int         n_bad = 0;

    mem_stage_ctrl #(.TIMEOUT_W(3), .CNT_W(4)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_mem_access(i_mem_access), .i_mem_we(i_mem_we),
        .i_ecall_instr(i_ecall_instr), .i_cause(i_cause), .i_mem_ready(i_mem_ready), .i_mem_err(i_mem_err),
        .i_load_use(i_load_use), .i_branch_mispred(i_branch_mispred), .o_mem_req(o_mem_req),
        .o_mem_req_we(o_mem_req_we), .o_stall_fetch(o_stall_fetch), .o_stall_dec(o_stall_dec),
        .o_stall_exec(o_stall_exec), .o_stall_mem(o_stall_mem), .o_flush_dec(o_flush_dec),
        .o_flush_exec(o_flush_exec), .o_flush_mem(o_flush_mem), .o_trap(o_trap),
        .o_trap_cause(o_trap_cause), .o_stall_cycles(o_stall_cycles)
    );

    // {stall fetch,dec,exec,mem, flush dec,exec,mem}
    assign ctl = {o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem, o_flush_dec, o_flush_exec, o_flush_mem};

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drv(input logic a, input logic we, input logic ec, input logic [3:0] cs,
                       input logic rd, input logic er, input logic lu, input logic bm);
        i_mem_access = a; i_mem_we = we; i_ecall_instr = ec; i_cause = cs;
        i_mem_ready = rd; i_mem_err = er; i_load_use = lu; i_branch_mispred = bm;
    endtask

    task automatic test_reset();
        #3 i_arst_n = 1'b0;
        drv(1, 1, 1, 4'd3, 0, 0, 1, 1);
        #1;
        n_cmp++;
        if ({o_mem_req, o_mem_req_we, ctl, o_trap, o_trap_cause, o_stall_cycles} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", {o_mem_req, o_mem_req_we, ctl, o_trap, o_trap_cause, o_stall_cycles});
        end
        @(negedge i_clk);
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        i_arst_n = 1'b1;
        tick();
    endtask

    task automatic test_hit();
        drv(1, 0, 0, 4'd0, 1, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_mem_req, ctl} !== 8'b1000_0000) begin
            n_bad++; $display("FAIL hit_req_ctl got %b want 10000000", {o_mem_req, ctl});
        end
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_mem_req, o_trap, o_stall_cycles} !== 6'd0) begin
            n_bad++; $display("FAIL hit_after got %h want 0", {o_mem_req, o_trap, o_stall_cycles});
        end
        tick();
    endtask

    task automatic test_miss();
        int st = 0;
        for (int i = 0; i < 4; i++) begin
            drv(i == 0, 1'b0, 0, 4'd0, i == 3, 0, 0, 0);
            if (i > 0) i_mem_we = 1'b1;
            #2;
            st += int'(o_stall_mem);
            n_cmp++;
            if ({o_mem_req, o_mem_req_we, ctl} !== {2'b10, (i < 3) ? 7'b1111000 : 7'b0000000}) begin
                n_bad++; $display("FAIL miss_cycle%0d got %b want %b", i, {o_mem_req, o_mem_req_we, ctl}, {2'b10, (i < 3) ? 7'b1111000 : 7'b0000000});
            end
            tick();
        end
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if (st != 3) begin
            n_bad++; $display("FAIL miss_stall_len got %0d want 3", st);
        end
        n_cmp++;
        if ({o_mem_req, o_trap, o_stall_cycles} !== 6'd3) begin
            n_bad++; $display("FAIL miss_idle_cnt got %h want 3", {o_mem_req, o_trap, o_stall_cycles});
        end
        tick();
    endtask

    task automatic test_timeout(input logic we, input int exp_cnt);
        int tc = -1;
        int st = 0;
        drv(1, we, 0, 4'd0, 0, 0, 0, 0);
        for (int i = 0; i < 12 && tc < 0; i++) begin
            #2;
            if (o_trap) begin
                tc = i;
                n_cmp++;
                if (o_trap_cause !== (we ? 4'd7 : 4'd5)) begin
                    n_bad++; $display("FAIL timeout_cause got %0d want %0d", o_trap_cause, we ? 7 : 5);
                end
                n_cmp++;
                if ({o_mem_req, ctl} !== 8'b0000_0111) begin
                    n_bad++; $display("FAIL timeout_trap_ctl got %b want 00000111", {o_mem_req, ctl});
                end
            end else begin
                st += int'(o_stall_mem);
                if (i > 0) begin
                    n_cmp++;
                    if ({o_mem_req, o_mem_req_we} !== {1'b1, we}) begin
                        n_bad++; $display("FAIL timeout_wait_req got %b want %b", {o_mem_req, o_mem_req_we}, {1'b1, we});
                    end
                end
            end
            tick();
            if (i == 0) begin
                i_mem_we = ~we;
                i_mem_access = 1'b0;
            end
        end
        n_cmp++;
        if (tc != 8 || st != 8) begin
            n_bad++; $display("FAIL timeout_latency got trap_at=%0d stalls=%0d want 8 8", tc, st);
        end
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_trap, o_trap_cause, o_mem_req, ctl} !== 13'd0) begin
            n_bad++; $display("FAIL timeout_exit got %b want 0", {o_trap, o_trap_cause, o_mem_req, ctl});
        end
        n_cmp++;
        if (int'(o_stall_cycles) != exp_cnt) begin
            n_bad++; $display("FAIL timeout_cnt got %0d want %0d", o_stall_cycles, exp_cnt);
        end
        tick();
    endtask

    task automatic test_mem_err();
        drv(1, 0, 0, 4'd0, 1, 1, 0, 0);
        #2;
        n_cmp++;
        if (ctl !== 7'd0) begin
            n_bad++; $display("FAIL err_idle_ctl got %b want 0", ctl);
        end
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_trap, o_trap_cause} !== 5'h15) begin
            n_bad++; $display("FAIL err_idle_trap got %h want 15", {o_trap, o_trap_cause});
        end
        tick();
        drv(1, 1, 0, 4'd0, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 4'd0, 1, 1, 0, 0);
        #2;
        n_cmp++;
        if ({o_mem_req, ctl} !== 8'b1000_0000) begin
            n_bad++; $display("FAIL err_wait_ctl got %b want 10000000", {o_mem_req, ctl});
        end
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_trap, o_trap_cause} !== 5'h17) begin
            n_bad++; $display("FAIL err_wait_trap got %h want 17", {o_trap, o_trap_cause});
        end
        tick();
    endtask

    task automatic test_priority();
        drv(1, 0, 1, 4'd2, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_trap, o_trap_cause} !== 5'h12) begin
            n_bad++; $display("FAIL prio_cause_over_ecall got %h want 12", {o_trap, o_trap_cause});
        end
        tick();
        drv(0, 0, 1, 4'd0, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_trap, o_trap_cause} !== 5'h1b) begin
            n_bad++; $display("FAIL prio_ecall got %h want 1b", {o_trap, o_trap_cause});
        end
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 1, 1);
        #2;
        n_cmp++;
        if (ctl !== 7'b0000110) begin
            n_bad++; $display("FAIL prio_bm_lu got %b want 0000110", ctl);
        end
        drv(0, 0, 0, 4'd0, 0, 0, 1, 0);
        #2;
        n_cmp++;
        if (ctl !== 7'b1100010) begin
            n_bad++; $display("FAIL load_use got %b want 1100010", ctl);
        end
        drv(1, 0, 0, 4'd0, 0, 0, 1, 1);
        #2;
        n_cmp++;
        if (ctl !== 7'b1111000) begin
            n_bad++; $display("FAIL prio_mem_over_flush got %b want 1111000", ctl);
        end
        tick();
        drv(0, 0, 0, 4'd0, 1, 0, 0, 0);
        tick();
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        #2;
        n_cmp++;
        if ({o_mem_req, o_trap, ctl} !== 9'd0) begin
            n_bad++; $display("FAIL prio_back_idle got %b want 0", {o_mem_req, o_trap, ctl});
        end
        tick();
    endtask

    task automatic test_reset_wait();
        drv(1, 0, 0, 4'd0, 0, 0, 0, 0);
        tick();
        tick();
        #2 i_arst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_mem_req, o_mem_req_we, ctl, o_trap, o_trap_cause, o_stall_cycles} !== 17'd0) begin
            n_bad++; $display("FAIL rst_wait_outputs got %h want 0", {o_mem_req, o_mem_req_we, ctl, o_trap, o_trap_cause, o_stall_cycles});
        end
        @(negedge i_clk);
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        i_arst_n = 1'b1;
        tick();
        #2;
        n_cmp++;
        if ({o_mem_req, ctl, o_trap, o_stall_cycles} !== 13'd0) begin
            n_bad++; $display("FAIL rst_wait_release got %h want 0", {o_mem_req, ctl, o_trap, o_stall_cycles});
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_arst_n = 1'b1;
        drv(0, 0, 0, 4'd0, 0, 0, 0, 0);
        test_reset();
        test_hit();
        test_miss();
        test_timeout(1'b1, 11);
        test_timeout(1'b0, 15);
        test_mem_err();
        test_priority();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL take parameter TIMEOUT_W, default 8: width of the memory-wait timeout counter.
REQ-002 The block SHALL take parameter CNT_W, default 32: width of the stall-cycle statistics counter.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports listed first:
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
REQ-004 The block SHALL have these request and hazard inputs:
- i_mem_access  in  1  memory-stage instruction is a load/store
- i_mem_we  in  1  memory-stage access is a store
- i_ecall_instr  in  1  memory-stage instruction is ECALL
- i_cause  in  4  upstream exception cause, 0 = none
- i_mem_ready  in  1  cache/bus data valid or write accepted
- i_mem_err  in  1  bus error, valid with i_mem_ready
- i_load_use  in  1  load-use hazard detected in decode
- i_branch_mispred  in  1  execute-stage branch mispredict
REQ-005 The block SHALL have these memory-request outputs:
- o_mem_req  out  1  memory request valid
- o_mem_req_we  out  1  request is a write
REQ-006 The block SHALL have these pipeline-control outputs:
- o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem  out  1 each  pipeline-register holds
- o_flush_dec, o_flush_exec, o_flush_mem  out  1 each  pipeline-register clears
REQ-007 The block SHALL have these trap and status outputs:
- o_trap  out  1  one-cycle trap pulse
- o_trap_cause  out  4  cause for o_trap
- o_stall_cycles  out  CNT_W  saturating count of memory-stall cycles

Function
REQ-008 The FSM SHALL have states IDLE, WAIT, TRAP; encoding is free.
REQ-009 IDLE SHALL drive o_mem_req = i_mem_access and o_mem_req_we = i_mem_we, combinationally.
REQ-010 Hit path: IDLE with i_mem_access=1, i_mem_ready=1, i_mem_err=0 SHALL complete with zero stall and stay in IDLE.
REQ-011 Miss path: IDLE with i_mem_access=1, i_mem_ready=0 SHALL go to WAIT and assert all four o_stall_* in that same cycle.
REQ-012 WAIT SHALL hold o_mem_req=1, hold o_mem_req_we stable, and assert all four o_stall_* until i_mem_ready=1.
REQ-013 In WAIT, i_mem_ready=1 with i_mem_err=0 SHALL release all stalls that cycle and return to IDLE.
REQ-014 A timeout counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-015 When the timeout counter reaches 2^TIMEOUT_W-1 with i_mem_ready=0, the FSM SHALL go to TRAP with cause 5 (load) or 7 (store).
REQ-016 i_mem_err=1 with i_mem_ready=1, in IDLE or WAIT, SHALL go to TRAP with cause 5 (load) or 7 (store).
REQ-017 In IDLE, i_ecall_instr=1 SHALL go to TRAP with cause 11.
REQ-018 In IDLE, i_cause!=0 SHALL go to TRAP with cause i_cause.
REQ-019 Trap-source priority SHALL be: i_cause, then ECALL, then memory error or timeout.
REQ-020 TRAP SHALL last exactly one cycle and drive o_trap=1, o_trap_cause=latched cause, o_flush_dec=o_flush_exec=o_flush_mem=1, all stalls 0, o_mem_req=0; it then returns to IDLE.
REQ-021 o_trap_cause SHALL read 0 whenever o_trap=0.
REQ-022 In IDLE with no memory stall, i_load_use=1 SHALL drive o_stall_fetch=o_stall_dec=1 and o_flush_exec=1.
REQ-023 In IDLE with no memory stall, i_branch_mispred=1 SHALL drive o_flush_dec=o_flush_exec=1 and no stalls.
REQ-024 Control-output priority SHALL be: TRAP, then memory stall, then branch mispredict, then load-use. A memory stall suppresses all flushes, and a mispredict suppresses load-use stalls.
REQ-025 o_stall_cycles SHALL increment in every cycle where o_stall_mem=1 and saturate at all-ones.
REQ-026 A stall SHALL NEVER be asserted together with a flush on the same pipeline register.

Reset
REQ-027 When i_arst_n=0, the block SHALL immediately force: FSM=IDLE, timeout counter=0, latched cause=0, o_stall_cycles=0.
REQ-028 When i_arst_n=0, every registered output SHALL be 0, and every combinational output SHALL be 0 regardless of its inputs.
REQ-029 Reset asserted during WAIT SHALL abort the request, driving o_mem_req=0 asynchronously.
REQ-030 Deassertion of i_arst_n SHALL take effect on the next rising edge of i_clk.

Verification
REQ-031 Hit: i_mem_access=1, i_mem_ready=1 -> o_mem_req=1, all stalls 0, o_stall_cycles stays 0.
REQ-032 Miss: load with i_mem_ready low for 3 cycles, then high -> o_stall_mem high for exactly 3 cycles, o_stall_cycles=3, FSM returns to IDLE.
REQ-033 Timeout (TIMEOUT_W=3): store with i_mem_ready held 0 -> o_trap pulses for one cycle with o_trap_cause=7 after 7 WAIT cycles; all three flushes are high in that cycle.
REQ-034 Simultaneous events: i_ecall_instr=1 and i_cause=2 -> o_trap_cause=2. i_branch_mispred=1 and i_load_use=1 -> flushes only, no stalls.
REQ-035 Reset mid-WAIT: drop i_arst_n after 2 stall cycles -> all outputs read 0 within the same cycle, FSM=IDLE after release, o_stall_cycles=0.
